mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have one clock and reset: reset is asynchronous and active-high; ports named clk and rst.
REQ-002 SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_we  out  1  PC write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALU out
- mem_we  out  1  data memory write enable
- ir_we  out  1  instruction register write enable
- reg_dst  out  1  register destination: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back source: 0 = ALU out, 1 = memory data
- reg_we  out  1  register file write enable
- alu_src_a  out  1  ALU A: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  00 = add, 01 = sub, 10 = decode funct
- pc_src  out  2  00 = ALU result, 01 = ALU out register, 10 = jump target
- state  out  4  current state, for debug
- instr_retired  out  32  count of retired instructions

Function
REQ-003 SHALL hold a state register with this encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-004 SHALL decode these opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-005 SHALL make these transitions:
- FETCH -> DECODE only when mem_ready=1, else stay in FETCH.
- DECODE -> MEMADR (lw, sw), EXEC (R-type), BRANCH (beq), ADDIEX (addi), JUMP (j).
- DECODE -> FETCH for any other opcode.
REQ-006 SHALL make these further transitions:
- MEMADR -> MEMRD (lw) or MEMWR (sw).
- MEMRD -> MEMWB on mem_ready=1, else stay in MEMRD.
- MEMWR -> FETCH on mem_ready=1, else stay in MEMWR.
- EXEC -> ALUWB; ADDIEX -> ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH unconditionally.
REQ-007 SHALL drive outputs combinationally from state, zero and mem_ready; every output not listed for a state SHALL be 0.
REQ-008 SHALL drive these FETCH outputs: alu_src_b=01, pc_we=mem_ready, ir_we=mem_ready; iord=0, alu_src_a=0, alu_op=00, pc_src=00.
REQ-009 SHALL drive these DECODE and MEMADR outputs:
- DECODE: alu_src_b=11.
- MEMADR: alu_src_a=1, alu_src_b=10.
REQ-010 SHALL drive these MEMRD, MEMWB and MEMWR outputs:
- MEMRD: iord=1.
- MEMWB: mem_to_reg=1, reg_we=1.
- MEMWR: iord=1, mem_we=1, held for every wait cycle.
REQ-011 SHALL drive these EXEC, ALUWB, ADDIEX and ADDIWB outputs:
- EXEC: alu_src_a=1, alu_op=10.
- ALUWB: reg_dst=1, reg_we=1.
- ADDIEX: alu_src_a=1, alu_src_b=10.
- ADDIWB: reg_we=1.
REQ-012 SHALL drive these BRANCH and JUMP outputs:
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01, pc_we=zero.
- JUMP: pc_src=10, pc_we=1.
REQ-013 SHALL increment instr_retired by 1 on each clock edge that enters FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP.
REQ-014 SHALL NOT increment instr_retired on a DECODE -> FETCH transition caused by an unknown opcode.
REQ-015 SHALL wrap instr_retired from 32'hFFFFFFFF to 0 with no flag.
REQ-016 SHALL give these latencies with mem_ready held at 1: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles. Each wait cycle adds 1.
REQ-017 SHALL take the opcode sampled in DECODE (and in MEMADR for the lw/sw choice); opcode changes in other states SHALL have no effect.

Reset
REQ-018 SHALL force state=FETCH and instr_retired=0 immediately when rst rises, at any state, including mid-wait in MEMRD or MEMWR.
REQ-019 SHALL hold pc_we, ir_we, mem_we and reg_we at 0 while rst=1, regardless of mem_ready; all other outputs SHALL take their FETCH values.
REQ-020 SHALL leave FETCH on the first rising clk edge after rst falls only if mem_ready=1.

Verification
REQ-021 SHALL cover: reset asserted in MEMWR with mem_ready=0 -> state=0, mem_we=0 asynchronously, instr_retired=0.
REQ-022 SHALL cover: lw with mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_we=1 only in state 4; instr_retired=1.
REQ-023 SHALL cover: sw with mem_ready low for 2 cycles in MEMWR -> state 5 held 3 cycles with mem_we=1 throughout; state=0 next; instr_retired +1.
REQ-024 SHALL cover: beq with zero=1 then beq with zero=0 -> pc_we=1 and pc_src=01 in state 8 for the first, pc_we=0 for the second.
REQ-025 SHALL cover: opcode 111111 -> states 0,1,0 with no write enables outside FETCH and instr_retired unchanged.
REQ-026 SHALL cover: instr_retired preloaded to 32'hFFFFFFFF via repeated j, then one more j -> instr_retired=0.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle CPU control unit: sequences fetch/decode/execute/memory/
// write-back, drives datapath controls, and counts retired instructions.
//
// state   | meaning
// --------+------------------------------------------------
// FETCH   | read instruction at PC, PC <= PC + 4
// DECODE  | read registers, precompute branch target
// MEMADR  | compute load/store effective address
// MEMRD   | load data read, waiting on mem_ready
// MEMWB   | load data written to rt
// MEMWR   | store data written, waiting on mem_ready
// EXEC    | R-type ALU operation
// ALUWB   | R-type result written to rd
// BRANCH  | beq compare, PC <= target when zero
// ADDIEX  | addi ALU operation
// ADDIWB  | addi result written to rt
// JUMP    | PC <= jump target
module mc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        iord,
    output logic        mem_we,
    output logic        ir_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_we,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [3:0]  state,
    output logic [31:0] instr_retired
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] retired_q;
    logic        retire;

    // State register; reset drops straight back to FETCH from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Retire counter; only completed instructions count, so an unknown
    // opcode bouncing DECODE -> FETCH is excluded. Wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         retired_q <= 32'd0;
        else if (retire) retired_q <= retired_q + 32'd1;
    end

    // Next-state selection and datapath control decode.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        pc_we      = 1'b0;
        iord       = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                // Gated by rst so no PC/IR write sneaks in while held in reset.
                pc_we     = mem_ready & ~rst;
                ir_we     = mem_ready & ~rst;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_we     = 1'b1;
                state_d    = FETCH;
                retire     = 1'b1;
            end
            MEMWR: begin
                iord   = 1'b1;
                mem_we = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_dst = 1'b1;
                reg_we  = 1'b1;
                state_d = FETCH;
                retire  = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_we     = zero;
                state_d   = FETCH;
                retire    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_we  = 1'b1;
                state_d = FETCH;
                retire  = 1'b1;
            end
            JUMP: begin
                pc_src  = 2'b10;
                pc_we   = 1'b1;
                state_d = FETCH;
                retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign state         = state_q;
    assign instr_retired = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: instruction-level reference model builds the
// expected per-cycle trace into a scoreboard queue; a negedge monitor pops
// and compares against the DUT.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_we, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state;
    logic [31:0] instr_retired;

    mc_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .iord(iord), .mem_we(mem_we), .ir_we(ir_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_we(reg_we),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .state(state), .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_BAD = 6;

    typedef struct {
        logic [3:0]  st;
        logic [13:0] outs;
        logic [31:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_ret;

    // Control word: pc_we iord mem_we ir_we reg_dst mem_to_reg reg_we alu_src_a alu_src_b alu_op pc_src
    function automatic logic [13:0] ctl(input logic pw, input logic io, input logic mw, input logic iw,
                                         input logic rd, input logic m2r, input logic rw, input logic sa,
                                         input logic [1:0] sb, input logic [1:0] op, input logic [1:0] ps);
        return {pw, io, mw, iw, rd, m2r, rw, sa, sb, op, ps};
    endfunction

    // Expected controls as tabulated per state in the requirements.
    function automatic logic [13:0] exp_outs(input logic [3:0] st, input logic z, input logic mr);
        case (st)
            4'd0:  return ctl(mr, 0, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
            4'd1:  return ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
            4'd2:  return ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
            4'd3:  return ctl(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
            4'd4:  return ctl(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
            4'd5:  return ctl(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
            4'd6:  return ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
            4'd7:  return ctl(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
            4'd8:  return ctl(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
            4'd9:  return ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
            4'd10: return ctl(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
            4'd11: return ctl(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
            default: return 14'd0;
        endcase
    endfunction

    function automatic logic [13:0] act_outs();
        return {pc_we, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we, alu_src_a,
                alu_src_b, alu_op, pc_src};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every cycle the driver scheduled is compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("state", {28'd0, state}, {28'd0, e.st});
            check("controls", {18'd0, act_outs()}, {18'd0, e.outs});
            check("instr_retired", instr_retired, e.ret);
        end
    end

    function automatic logic [5:0] kind_op(input int k);
        case (k)
            K_LW:   return 6'b100011;
            K_SW:   return 6'b101011;
            K_R:    return 6'b000000;
            K_BEQ:  return 6'b000100;
            K_ADDI: return 6'b001000;
            K_J:    return 6'b000010;
            default: begin
                logic [5:0] o;
                do o = 6'($urandom_range(0, 63));
                while (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
                return o;
            end
        endcase
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: apply inputs, record what the DUT should show.
    task automatic drive(input logic [3:0] st, input logic [5:0] opc, input logic z, input logic mr);
        opcode    = opc;
        zero      = z;
        mem_ready = mr;
        exp_q.push_back('{st, exp_outs(st, z, mr), model_ret});
        @(posedge clk);
        #1;
    endtask

    // Whole instruction: expected state path from opcode class and wait counts.
    task automatic run_instr(input int k, input int wf, input int wm, input logic zv);
        logic [5:0] op;
        op = kind_op(k);
        for (int i = 0; i < wf; i++) drive(4'd0, rop(), rbit(), 1'b0);
        drive(4'd0, rop(), rbit(), 1'b1);
        drive(4'd1, op, rbit(), rbit());
        case (k)
            K_LW: begin
                drive(4'd2, op, rbit(), rbit());
                for (int i = 0; i < wm; i++) drive(4'd3, rop(), rbit(), 1'b0);
                drive(4'd3, rop(), rbit(), 1'b1);
                drive(4'd4, rop(), rbit(), rbit());
            end
            K_SW: begin
                drive(4'd2, op, rbit(), rbit());
                for (int i = 0; i < wm; i++) drive(4'd5, rop(), rbit(), 1'b0);
                drive(4'd5, rop(), rbit(), 1'b1);
            end
            K_R: begin
                drive(4'd6, rop(), rbit(), rbit());
                drive(4'd7, rop(), rbit(), rbit());
            end
            K_BEQ:  drive(4'd8, rop(), zv, rbit());
            K_ADDI: begin
                drive(4'd9, rop(), rbit(), rbit());
                drive(4'd10, rop(), rbit(), rbit());
            end
            K_J:    drive(4'd11, rop(), rbit(), rbit());
            default: ;
        endcase
        if (k != K_BAD) model_ret = model_ret + 32'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_ret = 32'd0;
        rst       = 1'b1;
        opcode    = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #12;
        // Held in reset with mem_ready high: no writes, FETCH controls.
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_ctl", {18'd0, act_outs()}, {18'd0, ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00)});
        check("rst_retired", instr_retired, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First edge after reset must wait for mem_ready.
        run_instr(K_LW, 2, 0, 1'b0);
        run_instr(K_LW, 0, 0, 1'b0);
        run_instr(K_SW, 0, 2, 1'b0);
        run_instr(K_BEQ, 0, 0, 1'b1);
        run_instr(K_BEQ, 0, 0, 1'b0);
        run_instr(K_BAD, 0, 0, 1'b0);
        run_instr(K_R, 1, 0, 1'b0);
        run_instr(K_ADDI, 0, 0, 1'b0);
        run_instr(K_J, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++)
            run_instr(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), rbit());

        // Counter wrap: deposit a value just below the top, then retire jumps.
        dut.retired_q <= 32'hFFFF_FFFD;
        model_ret = 32'hFFFF_FFFD;
        #1;
        run_instr(K_J, 0, 0, 1'b0);
        run_instr(K_J, 0, 0, 1'b0);
        run_instr(K_J, 0, 0, 1'b0);
        check("wrap_retired", instr_retired, 32'd0);
        run_instr(K_ADDI, 0, 0, 1'b0);

        // Reset asserted mid-wait in MEMWR with mem_ready low.
        drive(4'd0, rop(), 1'b0, 1'b1);
        drive(4'd1, 6'b101011, 1'b0, 1'b1);
        drive(4'd2, 6'b101011, 1'b0, 1'b1);
        drive(4'd5, rop(), 1'b0, 1'b0);
        mem_ready = 1'b0;
        #1;
        check("memwr_before_rst", {28'd0, state}, 32'd5);
        rst = 1'b1;
        #1;
        check("async_rst_state", {28'd0, state}, 32'd0);
        check("async_rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("async_rst_retired", instr_retired, 32'd0);
        mem_ready = 1'b1;
        #1;
        check("rst_pc_ir_we", {30'd0, pc_we, ir_we}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_ret = 32'd0;
        run_instr(K_SW, 1, 1, 1'b0);
        run_instr(K_LW, 0, 1, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
